// File: rtl/seq_mul_pkg.sv
// -----------------------------------------------------------------------------
// seq_mul_pkg
//
// Shared definitions for the sequential radix-4 Booth multiplier:
//   - mul_state_e : control FSM states (IDLE / RUN / DONE)
//   - booth_sel_e : partial-product select codes produced by booth_r4_enc
//   - booth_steps : number of Booth steps K for a given operand width
//
// Optional feature macro used by the multiplier: SEQ_MUL_OVF_EN
// -----------------------------------------------------------------------------
package seq_mul_pkg;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Radix-4 Booth partial-product selections.
    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_POS1 = 3'd1,
        SEL_POS2 = 3'd2,
        SEL_NEG1 = 3'd3,
        SEL_NEG2 = 3'd4
    } booth_sel_e;

    // Operands are widened by two bits before recoding, so the recoded
    // multiplier is (width + 2) bits long and needs (width + 2) / 2 steps.
    function automatic int booth_steps(input int width);
        return width / 2 + 1;
    endfunction

endpackage : seq_mul_pkg

// File: rtl/booth_r4_enc.sv
// -----------------------------------------------------------------------------
// booth_r4_enc
//
// Combinational radix-4 Booth recoder. Maps one overlapping multiplier
// triplet {b[2i+1], b[2i], b[2i-1]} to a partial-product selection.
//
// Ports:
//   triplet_i  in  3  multiplier bits {b[2i+1], b[2i], b[2i-1]}
//   sel_o      out 3  selection code (booth_sel_e value)
//   neg_o      out 1  1 when the selected multiple must be subtracted
// -----------------------------------------------------------------------------
module booth_r4_enc
    import seq_mul_pkg::*;
(
    input  logic [2:0] triplet_i,
    output logic [2:0] sel_o,
    output logic       neg_o
);

    always_comb begin
        sel_o = SEL_ZERO;
        unique case (triplet_i)
            3'b001, 3'b010: sel_o = SEL_POS1;
            3'b011:         sel_o = SEL_POS2;
            3'b100:         sel_o = SEL_NEG2;
            3'b101, 3'b110: sel_o = SEL_NEG1;
            default:        sel_o = SEL_ZERO;
        endcase
    end

    // Negative for 100/101/110; 111 is a plain zero, never a "negative zero".
    assign neg_o = triplet_i[2] & ~(&triplet_i);

endmodule : booth_r4_enc

// File: rtl/seq_booth_multiplier.sv
// -----------------------------------------------------------------------------
// seq_booth_multiplier
//
// Multi-cycle radix-4 Booth multiplier with runtime signed/unsigned mode.
// Retires two multiplier bits per clock; the product is bit-exact to the
// full 2*WIDTH-bit signed or unsigned product of the latched operands.
//
// Parameters:
//   WIDTH      operand width (even, >= 4), default 32
//
// Ports:
//   clk        in   1          clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   start      in   1          request, sampled only in IDLE
//   is_signed  in   1          1 = two's-complement operands, 0 = unsigned
//   a          in   WIDTH      multiplicand, latched on accepted start
//   b          in   WIDTH      multiplier, latched on accepted start
//   busy       out  1          high whenever the FSM is not in IDLE
//   done       out  1          one-cycle pulse when product becomes valid
//   product    out  2*WIDTH    result register, held until the next result
//   ovf        out  1          (only with SEQ_MUL_OVF_EN) product does not
//                              fit in WIDTH bits for the latched mode
//
// Optional feature macro: SEQ_MUL_OVF_EN (adds the ovf output and its logic).
//
// Timing: start accepted at edge T -> product/done update at edge T+K with
// K = WIDTH/2 + 1; busy falls at edge T+K+1.
// -----------------------------------------------------------------------------
module seq_booth_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
`ifdef SEQ_MUL_OVF_EN
    output logic [2*WIDTH-1:0] product,
    output logic               ovf
`else
    output logic [2*WIDTH-1:0] product
`endif
);

    // Extended operand width and accumulator width.
    localparam int EXT_W = WIDTH + 2;
    localparam int ACC_W = 2 * EXT_W;
    localparam int K     = booth_steps(WIDTH);
    localparam int CNT_W = $clog2(K);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
        $error("seq_booth_multiplier: WIDTH must be even and >= 4");
    end

    // Two extra bits make the unsigned case exact: a zero-extended operand
    // is non-negative as a signed (WIDTH+2)-bit value, and the step count
    // is the same in both modes.
    function automatic logic [EXT_W-1:0] extend(input logic [WIDTH-1:0] x,
                                               input logic             s);
        return {{2{s & x[WIDTH-1]}}, x};
    endfunction

`ifdef SEQ_MUL_OVF_EN
    // Upper half carries information beyond what the lower half represents.
    function automatic logic ovf_of(input logic [2*WIDTH-1:0] p,
                                    input logic               s);
        if (s) begin
            return p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}};
        end
        return |p[2*WIDTH-1:WIDTH];
    endfunction
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    mul_state_e           state_q,   state_d;
    logic [EXT_W-1:0]     mcand_q,   mcand_d;    // extended multiplicand
    // Accumulator: upper EXT_W bits hold the running partial sum, lower
    // EXT_W bits start as the extended multiplier and are shifted out two
    // bits per step as product bits shift in from above.
    logic [ACC_W-1:0]     acc_q,     acc_d;
    logic                 prev_q,    prev_d;     // b[2i-1] for the next triplet
    logic [CNT_W-1:0]     step_q,    step_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
`ifdef SEQ_MUL_OVF_EN
    logic                 signed_q,  signed_d;
    logic                 ovf_q,     ovf_d;
`endif

    // -------------------------------------------------------------------------
    // Booth step datapath
    // -------------------------------------------------------------------------
    logic [2:0]           triplet;
    logic [2:0]           sel;
    logic                 neg;
    logic [EXT_W+1:0]     mag;       // |selected multiple|, two guard bits
    logic [EXT_W+1:0]     addend;
    logic [EXT_W+1:0]     hi_wide;
    logic [EXT_W+1:0]     sum;
    logic [ACC_W-1:0]     acc_step;
    logic                 last_step;

    assign triplet = {acc_q[1:0], prev_q};

    booth_r4_enc u_enc (
        .triplet_i (triplet),
        .sel_o     (sel),
        .neg_o     (neg)
    );

    always_comb begin
        mag = '0;
        unique case (sel)
            SEL_POS1, SEL_NEG1: mag = {{2{mcand_q[EXT_W-1]}}, mcand_q};
            SEL_POS2, SEL_NEG2: mag = {mcand_q[EXT_W-1], mcand_q, 1'b0};
            default:            mag = '0;
        endcase
    end

    assign addend  = neg ? (~mag + 1'b1) : mag;
    // The partial sum plus +/-2A can exceed EXT_W bits before the shift, so
    // the add is done two bits wider; keeping the whole sum and dropping two
    // low bits of the accumulator is exactly the arithmetic shift by 2.
    assign hi_wide  = {{2{acc_q[ACC_W-1]}}, acc_q[ACC_W-1:EXT_W]};
    assign sum      = hi_wide + addend;
    assign acc_step = {sum, acc_q[EXT_W-1:2]};

    assign last_step = (step_q == CNT_W'(K - 1));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        prev_d    = prev_q;
        step_d    = step_q;
        product_d = product_q;
`ifdef SEQ_MUL_OVF_EN
        signed_d  = signed_q;
        ovf_d     = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    mcand_d  = extend(a, is_signed);
                    acc_d    = {{EXT_W{1'b0}}, extend(b, is_signed)};
                    prev_d   = 1'b0;
                    step_d   = '0;
`ifdef SEQ_MUL_OVF_EN
                    signed_d = is_signed;
`endif
                end
            end
            RUN: begin
                acc_d  = acc_step;
                prev_d = acc_q[1];
                step_d = step_q + 1'b1;
                if (last_step) begin
                    state_d   = DONE;
                    product_d = acc_step[2*WIDTH-1:0];
`ifdef SEQ_MUL_OVF_EN
                    ovf_d     = ovf_of(acc_step[2*WIDTH-1:0], signed_q);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            prev_q    <= 1'b0;
            step_q    <= '0;
            product_q <= '0;
`ifdef SEQ_MUL_OVF_EN
            signed_q  <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            prev_q    <= prev_d;
            step_q    <= step_d;
            product_q <= product_d;
`ifdef SEQ_MUL_OVF_EN
            signed_q  <= signed_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = product_q;
`ifdef SEQ_MUL_OVF_EN
    assign ovf     = ovf_q;
`endif

endmodule : seq_booth_multiplier

// File: tb/tb_seq_booth_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_booth_multiplier
//
// Directed and random checks of seq_booth_multiplier at WIDTH = 32, 8, 64.
// Outputs are sampled on the falling clock edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_seq_booth_multiplier;

    localparam int K32 = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // WIDTH = 32 instance
    logic        start32 = 1'b0, s32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [63:0] p32;
    // WIDTH = 8 instance
    logic        start8 = 1'b0, s8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] p8;
    // WIDTH = 64 instance
    logic        start64 = 1'b0, s64 = 1'b0;
    logic [63:0] a64 = '0, b64 = '0;
    logic        busy64, done64;
    logic [127:0] p64;
`ifdef SEQ_MUL_OVF_EN
    logic ovf32, ovf8, ovf64;
`endif

    seq_booth_multiplier #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .is_signed(s32),
        .a(a32), .b(b32), .busy(busy32), .done(done32),
`ifdef SEQ_MUL_OVF_EN
        .product(p32), .ovf(ovf32)
`else
        .product(p32)
`endif
    );

    seq_booth_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(s8),
        .a(a8), .b(b8), .busy(busy8), .done(done8),
`ifdef SEQ_MUL_OVF_EN
        .product(p8), .ovf(ovf8)
`else
        .product(p8)
`endif
    );

    seq_booth_multiplier #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .is_signed(s64),
        .a(a64), .b(b64), .busy(busy64), .done(done64),
`ifdef SEQ_MUL_OVF_EN
        .product(p64), .ovf(ovf64)
`else
        .product(p64)
`endif
    );

    // Directed vectors: operands, mode, hand-computed product and overflow.
    localparam int NV = 8;
    logic [31:0] dv_a   [NV] = '{32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [31:0] dv_b   [NV] = '{32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                 32'h8000_0000, 32'h0000_0002, 32'h1234_5678, 32'h0000_0001};
    logic        dv_s   [NV] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [63:0] dv_p   [NV] = '{64'hFFFF_FFFF_FFFF_FFD6, 64'hFFFF_FFFE_0000_0001,
                                 64'h0000_0000_0000_0001, 64'h4000_0000_0000_0000,
                                 64'hC000_0000_8000_0000, 64'h0000_0001_0000_0000,
                                 64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    logic        dv_ovf [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // One WIDTH=32 multiply: start accepted at the next rising edge (T);
    // n counts falling edges after T. Optionally re-pulses start with other
    // operands at n == poke_at. Returns the first product seen with done.
    task automatic run_mul32(input logic [31:0] ta, input logic [31:0] tbv,
                             input logic ts, input int poke_at,
                             output logic [63:0] p, output int done_edge,
                             output int busy_n, output int pulses);
        @(negedge clk);
        a32 = ta; b32 = tbv; s32 = ts; start32 = 1'b1;
        @(posedge clk);
        done_edge = -1; busy_n = 0; pulses = 0; p = '0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (busy32) busy_n++;
            if (done32) begin
                pulses++;
                if (done_edge < 0) begin
                    done_edge = n;
                    p = p32;
                end
            end
            if (n == poke_at) begin
                start32 = 1'b1; a32 = ~ta; b32 = tbv + 32'd1; s32 = ~ts;
            end else begin
                start32 = 1'b0;
            end
            if (!busy32) break;
            @(posedge clk);
        end
        start32 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || p32 !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b product=%h, required 0 0 0", busy32, done32, p32);
        end
`ifdef SEQ_MUL_OVF_EN
        n_tests++;
        if (ovf32 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: ovf=%b, required 0", ovf32);
        end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy32 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b, required 0", busy32);
        end
    endtask

    task automatic test_directed();
        logic [63:0] p;
        int de, bn, pl;
        for (int i = 0; i < NV; i++) begin
            run_mul32(dv_a[i], dv_b[i], dv_s[i], -1, p, de, bn, pl);
            $display("[TB] directed %0d: a=%h b=%h signed=%b product=%h", i, dv_a[i], dv_b[i], dv_s[i], p);
            n_tests++;
            if (p !== dv_p[i]) begin
                n_fail++;
                $display("FAIL directed_product[%0d]: got %h, required %h", i, p, dv_p[i]);
            end
            n_tests++;
            if (de != K32 || pl != 1) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: done at edge %0d with %0d pulses, required edge %0d with 1", i, de, pl, K32);
            end
            n_tests++;
            if (bn != K32 + 1) begin
                n_fail++;
                $display("FAIL directed_busy[%0d]: busy for %0d cycles, required %0d", i, bn, K32 + 1);
            end
`ifdef SEQ_MUL_OVF_EN
            n_tests++;
            if (u_ovf_sample(i) !== dv_ovf[i]) begin
                n_fail++;
                $display("FAIL directed_ovf[%0d]: got %b, required %b", i, ovf32, dv_ovf[i]);
            end
`endif
        end
    endtask

`ifdef SEQ_MUL_OVF_EN
    // ovf is held with product, so it can be read once the run is back in IDLE.
    function automatic logic u_ovf_sample(input int idx);
        return (idx >= 0) ? ovf32 : 1'b0;
    endfunction
`endif

    task automatic test_ignore_start();
        logic [63:0] p;
        int de, bn, pl, extra;
        run_mul32(32'd3, 32'd5, 1'b0, 5, p, de, bn, pl);
        $display("[TB] ignore_start: 3*5 with mid-run start, product=%h pulses=%0d", p, pl);
        n_tests++;
        if (p !== 64'd15 || pl != 1 || de != K32) begin
            n_fail++;
            $display("FAIL ignore_start: product=%h pulses=%0d edge=%0d, required %h 1 %0d", p, pl, de, 64'd15, K32);
        end
        extra = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done32 || busy32) extra++;
        end
        n_tests++;
        if (extra != 0 || p32 !== 64'd15) begin
            n_fail++;
            $display("FAIL no_queue: %0d busy/done cycles, product=%h, required 0 and %h", extra, p32, 64'd15);
        end
    endtask

    task automatic test_back_to_back();
        int edges [3];
        int got;
        got = 0;
        @(negedge clk);
        a32 = 32'h0001_2345; b32 = 32'h0000_0010; s32 = 1'b0; start32 = 1'b1;
        for (int n = 1; n <= 80 && got < 3; n++) begin
            @(negedge clk);
            if (done32) begin
                edges[got] = n;
                got++;
                n_tests++;
                if (p32 !== 64'h0000_0000_0012_3450) begin
                    n_fail++;
                    $display("FAIL b2b_product[%0d]: got %h, required %h", got, p32, 64'h0000_0000_0012_3450);
                end
            end
        end
        start32 = 1'b0;
        // One DONE cycle plus one IDLE cycle separate consecutive runs.
        n_tests++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL b2b_count: %0d results, required 3", got);
        end else begin
            $display("[TB] back_to_back: done at %0d %0d %0d", edges[0], edges[1], edges[2]);
            if (edges[1] - edges[0] != K32 + 2 || edges[2] - edges[1] != K32 + 2) begin
                n_fail++;
                $display("FAIL b2b_spacing: %0d and %0d cycles, required %0d", edges[1] - edges[0], edges[2] - edges[1], K32 + 2);
            end
        end
        for (int n = 0; n < 40 && busy32; n++) @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        logic [63:0] p;
        int de, bn, pl, stray;
        @(negedge clk);
        a32 = 32'h1111_1111; b32 = 32'h2222_2222; s32 = 1'b0; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || p32 !== 64'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: busy=%b done=%b product=%h, required 0 0 0", busy32, done32, p32);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done32 || busy32) stray++;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL midrun_no_done: %0d busy/done cycles after abort, required 0", stray);
        end
        run_mul32(32'h1111_1111, 32'h2222_2222, 1'b0, -1, p, de, bn, pl);
        $display("[TB] after_reset: product=%h", p);
        n_tests++;
        if (p !== 64'h0246_8ACF_0ECA_8642 || de != K32) begin
            n_fail++;
            $display("FAIL after_reset_product: got %h at edge %0d, required %h at %0d", p, de, 64'h0246_8ACF_0ECA_8642, K32);
        end
    endtask

    task automatic test_random_w32();
        logic [63:0] p, exp_p;
        logic [31:0] ra, rb;
        logic rs;
        int de, bn, pl;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            exp_p = rs ? ($signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb}))
                       : ({32'd0, ra} * {32'd0, rb});
            run_mul32(ra, rb, rs, -1, p, de, bn, pl);
            n_tests++;
            if (p !== exp_p || de != K32) begin
                n_fail++;
                $display("FAIL random32[%0d]: a=%h b=%h s=%b got %h, required %h", i, ra, rb, rs, p, exp_p);
                break;
            end
        end
        $display("[TB] random32 finished");
    endtask

    task automatic test_random_w8();
        logic [15:0] exp_p;
        int got;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
            s8 = 1'($urandom_range(0, 1)); start8 = 1'b1;
            exp_p = s8 ? ($signed({{8{a8[7]}}, a8}) * $signed({{8{b8[7]}}, b8}))
                       : ({8'd0, a8} * {8'd0, b8});
            @(posedge clk);
            @(negedge clk);
            start8 = 1'b0;
            got = 0;
            for (int n = 0; n < 40; n++) begin
                if (done8) begin got = 1; break; end
                @(negedge clk);
            end
            n_tests++;
            if (got == 0 || p8 !== exp_p) begin
                n_fail++;
                $display("FAIL random8[%0d]: a=%h b=%h s=%b done=%0d got %h, required %h", i, a8, b8, s8, got, p8, exp_p);
                break;
            end
        end
        $display("[TB] random8 finished");
    endtask

    task automatic test_random_w64();
        logic [127:0] exp_p;
        int got;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
            s64 = 1'($urandom_range(0, 1)); start64 = 1'b1;
            exp_p = s64 ? ($signed({{64{a64[63]}}, a64}) * $signed({{64{b64[63]}}, b64}))
                        : ({64'd0, a64} * {64'd0, b64});
            @(posedge clk);
            @(negedge clk);
            start64 = 1'b0;
            got = 0;
            for (int n = 0; n < 60; n++) begin
                if (done64) begin got = 1; break; end
                @(negedge clk);
            end
            n_tests++;
            if (got == 0 || p64 !== exp_p) begin
                n_fail++;
                $display("FAIL random64[%0d]: a=%h b=%h s=%b done=%0d got %h, required %h", i, a64, b64, s64, got, p64, exp_p);
                break;
            end
        end
        $display("[TB] random64 finished");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        test_random_w32();
        test_random_w8();
        test_random_w64();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_seq_booth_multiplier
